// File: rtl/dsf_pkg.sv
// Shared definitions for domain_slot_fifo: id widths, security labels and the
// scrub state encoding.
package dsf_pkg;

  // Scrub sequencer states (used only when DOMAIN_SCRUB_EN is defined).
  typedef enum logic [0:0] {
    SCRUB_IDLE   = 1'b0,
    SCRUB_ACTIVE = 1'b1
  } scrub_state_t;

  // Security labels: L (public), H (secret), Dk (owned by domain k).
  typedef logic [3:0] label_t;
  localparam label_t LBL_L = 4'd0;
  localparam label_t LBL_H = 4'd1;

  // Label of domain k's private data.
  function automatic label_t lbl_dom(input int k);
    return label_t'(k + 2);
  endfunction

  // Bits needed to index n items; at least one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dom_partition.sv
// One domain's private FIFO partition: storage, rd/wr pointers, occupancy count
// and a zeroing write port driven by the scrub sequencer.
// With DOMAIN_SCRUB_EN defined the storage array also resets to zero.
module dom_partition
  import dsf_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int AW    = id_width(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  input  logic             scrub_we,
  input  logic [AW-1:0]    scrub_addr,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  // Pointer and count update; clear (flush) overrides any push/pop this cycle.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef DOMAIN_SCRUB_EN
  // Storage write port; scrub zeroes one entry per cycle, array resets to zero.
  // NOTE: the array is reset only in the scrub build, where stale secrets must never survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (scrub_we) begin
      mem[scrub_addr] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end
`else
  // Storage write port; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (scrub_we) begin
      mem[scrub_addr] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end
`endif

  assign head_data = mem[rd_ptr];
  assign count     = cnt;
  assign full      = (cnt == CW'(DEPTH));

endmodule

// File: rtl/domain_slot_fifo.sv
// Multi-domain FIFO: one static partition per security domain and a fixed
// round-robin time-slot output scheduler whose timing never depends on occupancy.
// Optional feature: define DOMAIN_SCRUB_EN to zero a flushed partition's storage
// over DEPTH cycles (and reset storage); otherwise flush is a one-cycle pointer clear.
module domain_slot_fifo
  import dsf_pkg::*;
#(
  parameter int  NDOM  = 4,
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  parameter int  SLOT  = 2,
  localparam int DW    = id_width(NDOM),
  localparam int AW    = id_width(DEPTH),
  localparam int CW    = AW + 1,
  localparam int SCW   = id_width(SLOT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_dom,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_dom,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush_valid,
  input  logic [DW-1:0]    flush_dom,
  output logic             flush_ready
);

  logic [SCW-1:0]   slot_cnt;
  logic [DW-1:0]    cur_slot;
  logic [NDOM-1:0]  push_vec;
  logic [NDOM-1:0]  pop_vec;
  logic [NDOM-1:0]  clear_vec;
  logic [NDOM-1:0]  full;
  logic [NDOM-1:0]  busy;
  logic [WIDTH-1:0] head      [NDOM];
  logic [CW-1:0]    dom_count [NDOM];
  logic [AW-1:0]    scrub_idx;
  logic             flush_fire;

  // Free-running slot scheduler: each domain owns the output for SLOT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      cur_slot <= '0;
    end else if (slot_cnt == SCW'(SLOT - 1)) begin
      slot_cnt <= '0;
      cur_slot <= cur_slot + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

`ifdef DOMAIN_SCRUB_EN
  scrub_state_t  state, state_d;
  logic [DW-1:0] scrub_dom, scrub_dom_d;
  logic [AW-1:0] scrub_idx_d;

  // Scrub sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCRUB_IDLE;
      scrub_dom <= '0;
      scrub_idx <= '0;
    end else begin
      state     <= state_d;
      scrub_dom <= scrub_dom_d;
      scrub_idx <= scrub_idx_d;
    end
  end

  // Scrub next state: accept a flush in IDLE, then walk every entry of that domain.
  always_comb begin
    state_d     = state;
    scrub_dom_d = scrub_dom;
    scrub_idx_d = scrub_idx;
    flush_ready = 1'b0;
    busy        = '0;
    case (state)
      SCRUB_IDLE: begin
        flush_ready = 1'b1;
        if (flush_valid) begin
          state_d     = SCRUB_ACTIVE;
          scrub_dom_d = flush_dom;
          scrub_idx_d = '0;
        end
      end
      SCRUB_ACTIVE: begin
        busy[scrub_dom] = 1'b1;
        scrub_idx_d     = scrub_idx + 1'b1;
        if (scrub_idx == AW'(DEPTH - 1)) state_d = SCRUB_IDLE;
      end
      default: state_d = SCRUB_IDLE;
    endcase
  end
`else
  assign flush_ready = 1'b1;
  assign busy        = '0;
  assign scrub_idx   = '0;
`endif

  assign flush_fire = flush_valid && flush_ready;

  // Input acceptance never looks at out_ready; a same-domain flush blocks the push.
  assign in_ready = !full[in_dom] && !busy[in_dom] &&
                    !(flush_fire && (flush_dom == in_dom));

  assign out_dom   = cur_slot;
  assign out_valid = (dom_count[cur_slot] != '0) && !busy[cur_slot];
  assign out_data  = head[cur_slot];

  // Steer push/pop/clear strobes to the addressed partition.
  // NOTE: vectors get a default before the loop so no latch is inferred.
  always_comb begin
    push_vec  = '0;
    pop_vec   = '0;
    clear_vec = '0;
    for (int d = 0; d < NDOM; d++) begin
      push_vec[d]  = in_valid && in_ready && (in_dom == DW'(d));
      pop_vec[d]   = out_valid && out_ready && (cur_slot == DW'(d));
      clear_vec[d] = flush_fire && (flush_dom == DW'(d));
    end
  end

  for (genvar d = 0; d < NDOM; d++) begin : g_dom
    dom_partition #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
    ) u_part (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_vec[d]),
      .push_data  (in_data),
      .pop        (pop_vec[d]),
      .clear      (clear_vec[d]),
      .scrub_we   (busy[d]),
      .scrub_addr (scrub_idx),
      .head_data  (head[d]),
      .count      (dom_count[d]),
      .full       (full[d])
    );
  end

endmodule
